// File: rtl/result_tx_pkg.sv
// Shared types and helpers for the result-to-UART byte sequencer.
// The header helper is only used when RESULT_TX_HEADER_EN is defined.
package result_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_BYTE,
        ST_POP
    } tx_state_e;

    localparam logic HDR_MARK     = 1'b1;
    localparam int   HDR_MARK_POS = 7;
    localparam int   HDR_CH_LSB   = 4;
    localparam int   HDR_CH_W     = 3;
    localparam int   HDR_LEN_LSB  = 0;
    localparam int   HDR_LEN_W    = 4;

    function automatic int bytes_of(input int data_w);
        return (data_w + 7) / 8;
    endfunction

    // Header byte layout: marker, channel index, byte count of the word.
    function automatic logic [7:0] hdr_byte(input logic [HDR_CH_W-1:0] ch, input int nbytes);
        logic [7:0] h;
        h = '0;
        h[HDR_MARK_POS]                 = HDR_MARK;
        h[HDR_CH_LSB +: HDR_CH_W]       = ch;
        h[HDR_LEN_LSB +: HDR_LEN_W]     = HDR_LEN_W'(nbytes);
        return h;
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Per-channel synchronous FIFO; a push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module result_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count;
    logic              do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/result_tx_sequencer.sv
// Captures per-channel result words, sends them in strict channel order as an
// AXI-stream byte master. Define RESULT_TX_HEADER_EN to prefix a header byte.
module result_tx_sequencer
    import result_tx_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int NUM_CH    = 2,
    parameter int DEPTH     = 4,
    parameter int GATE_CH   = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        done,
    input  logic [NUM_CH*DATA_W-1:0] data,
    input  logic                     send,
    output logic [7:0]               m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [NUM_CH-1:0]        overflow,
    output logic                     busy
);
    localparam int BYTES = bytes_of(DATA_W);
    localparam int PAD_W = BYTES * 8;
    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BI_W  = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [NUM_CH-1:0]             full, empty, pop;
    logic [NUM_CH-1:0][DATA_W-1:0] head;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        result_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (done[k]),
            .pop   (pop[k]),
            .din   (data[k*DATA_W +: DATA_W]),
            .dout  (head[k]),
            .full  (full[k]),
            .empty (empty[k])
        );
    end

    tx_state_e        state;
    logic [PTR_W-1:0] ptr;
    logic [BI_W-1:0]  bidx;
    logic             released;
    logic             send_s0, send_s1, send_d;

    logic [DATA_W-1:0] cur_word;
    logic              cur_empty, gated, send_rise, go, last, hs;
    logic [PTR_W-1:0]  next_ptr;

    function automatic logic [7:0] byte_sel(input logic [DATA_W-1:0] w, input int i);
        logic [PAD_W-1:0] p;
        int               j;
        p = PAD_W'(w);
        j = (MSB_FIRST != 0) ? (BYTES - 1 - i) : i;
        return p[j*8 +: 8];
    endfunction

    always_comb begin
        cur_word  = '0;
        cur_empty = 1'b1;
        pop       = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ptr == PTR_W'(k)) begin
                cur_word  = head[k];
                cur_empty = empty[k];
                pop[k]    = (state == ST_POP);
            end
        end
    end

    assign gated     = (int'(ptr) >= GATE_CH);
    assign send_rise = send_s1 && !send_d;
    // A send edge arriving in the same cycle as a non-empty gated head releases it immediately.
    assign go        = (state == ST_IDLE) && !cur_empty && (!gated || released || send_rise);
    assign last      = (int'(bidx) == BYTES - 1);
    assign hs        = m_axis_tvalid && m_axis_tready;
    assign next_ptr  = (int'(ptr) == NUM_CH - 1) ? '0 : ptr + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            send_s0 <= 1'b0;
            send_s1 <= 1'b0;
            send_d  <= 1'b0;
        end else begin
            send_s0 <= send;
            send_s1 <= send_s0;
            send_d  <= send_s1;
        end
    end

    // A full FIFO that pops in the same cycle takes the push, so it is not an overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) overflow <= '0;
        else      overflow <= overflow | (done & full & ~pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            ptr           <= '0;
            bidx          <= '0;
            released      <= 1'b0;
            busy          <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
        end else begin
            // Edges only count while parked on a gated channel; one edge = one word.
            if (state == ST_IDLE && gated && send_rise) released <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        released      <= 1'b0;
                        busy          <= 1'b1;
                        bidx          <= '0;
                        m_axis_tvalid <= 1'b1;
`ifdef RESULT_TX_HEADER_EN
                        m_axis_tdata  <= hdr_byte(HDR_CH_W'(ptr), BYTES);
                        state         <= ST_HDR;
`else
                        m_axis_tdata  <= byte_sel(cur_word, 0);
                        state         <= ST_BYTE;
`endif
                    end
                end
`ifdef RESULT_TX_HEADER_EN
                ST_HDR: begin
                    if (hs) begin
                        m_axis_tdata <= byte_sel(cur_word, 0);
                        state        <= ST_BYTE;
                    end
                end
`endif
                ST_BYTE: begin
                    if (hs) begin
                        if (last) begin
                            m_axis_tvalid <= 1'b0;
                            state         <= ST_POP;
                        end else begin
                            bidx         <= bidx + 1'b1;
                            m_axis_tdata <= byte_sel(cur_word, int'(bidx) + 1);
                        end
                    end
                end
                ST_POP: begin
                    ptr   <= next_ptr;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/result_tx_sequencer.md
# result_tx_sequencer

Parametrised result-to-UART sequencer sitting between the crypto core outputs and the UART transmitter's AXI-stream input. It captures completed result words from NUM_CH channels into per-channel FIFOs, services them in strict channel order, serialises each DATA_W-bit word into bytes, and drives a fully compliant AXI-stream byte master. Channels from GATE_CH upward are released only on a synchronised rising edge of the `send` push-button.

## Interface
- DATA_W, 8 — result word width in bits, 1..64; byte count BYTES = ceil(DATA_W/8).
- NUM_CH, 2 — number of result channels, 1..8 (ch0 = encrypted, ch1 = decrypted).
- DEPTH, 4 — per-channel FIFO depth, power of two, ≥2.
- GATE_CH, 1 — first channel index requiring a `send` edge; NUM_CH disables gating.
- MSB_FIRST, 1 — 1: most-significant byte first; 0: least-significant first.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- done  in  NUM_CH  per-channel one-cycle result-valid strobe.
- data  in  NUM_CH*DATA_W  result words, channel k at [k*DATA_W +: DATA_W].
- send  in  1  asynchronous push-button.
- m_axis_tdata  out  8  byte to UART.
- m_axis_tvalid  out  1  byte valid.
- m_axis_tready  in  1  UART ready.
- overflow  out  NUM_CH  sticky per-channel FIFO-overflow flag.
- busy  out  1  high while a word is being serialised.

## Operation
- Capture: `done[k]` high pushes `data[k]` into FIFO k in the same cycle. If FIFO k is full, the word is dropped, `overflow[k]` sets and stays set until reset.
- Order: a round services ch0, ch1, …, ch NUM_CH-1 in sequence; the pointer waits on channel k until FIFO k is non-empty, so ch1 is never sent ahead of its ch0 partner.
- Gating: for k ≥ GATE_CH, the word is released only after a `send` rising edge seen while waiting on k. One edge releases exactly one word; edges while not waiting on a gated channel are ignored.
- `send`: two-flop synchroniser, then edge detect on synchronised level.
- States: IDLE (waiting on pointer channel) → BYTE (present byte i, i = 0..BYTES-1) → POP (pop FIFO, advance pointer modulo NUM_CH) → IDLE. With RESULT_TX_HEADER_EN, IDLE → HDR → BYTE.
- Byte i: MSB_FIRST=1 sends word[(BYTES-1-i)*8 +: 8]; bits above DATA_W are zero-padded.
- AXI rule: once `m_axis_tvalid` rises, `tdata` and `tvalid` hold until `tready`; `tvalid` never drops without a handshake.
- Reset mid-word: FIFOs emptied, pointer → ch0, state → IDLE, partial word discarded and not resent.

## Timing
- Reset values: m_axis_tdata=0, m_axis_tvalid=0, overflow=0, busy=0; synchroniser flops 0.
- Push at edge N → earliest `tvalid` at edge N+1 (empty FIFO, ungated, tready high).
- One byte per cycle while `tready` is high; a full word takes BYTES cycles + 1 POP cycle.
- `send` edge → release ≥3 cycles later (2 sync + 1 detect).
- Simultaneous push and pop on the same FIFO: both occur; a full FIFO popping that cycle accepts the push without overflow.
- Simultaneous `done` on all channels: all captured in the same cycle.

## Configuration
- RESULT_TX_HEADER_EN defined: every word is preceded by a header byte {1'b1, ch[2:0], BYTES[3:0]} (BYTES capped at 8, encoded BYTES-1 in 4 bits is not used; value is BYTES), with the same AXI hold rules. Word cost BYTES+2 cycles.
- Undefined: no header; HDR state and its logic are absent.

## Structure
- Package `result_tx_pkg`: state enum (IDLE, HDR, BYTE, POP), function `bytes_of(DATA_W)`, header MSB marker constant and field positions.
- Sub-module `result_fifo`: synchronous FIFO (DATA_W, DEPTH), push/pop/full/empty, async active-low reset; instantiated NUM_CH times via generate.

## Test plan
- DATA_W=8: done[0] with 0xA5, then done[1] with 0x5A, send edge → bytes 0xA5 then 0x5A; 0x5A not sent before the edge.
- DATA_W=16, MSB_FIRST=1, GATE_CH=2: ch0=0x1234, ch1=0xBEEF → 0x12,0x34,0xBE,0xEF; MSB_FIRST=0 → 0x34,0x12,0xEF,0xBE.
- tready low for 5 cycles mid-word → tdata/tvalid stable throughout, no byte lost or duplicated.
- DEPTH=4: 5 strobes on ch0 while tready=0 → overflow[0]=1, exactly 4 words emitted after release.
- Three send edges while waiting on ch1 with three ch1 words queued (ch0 words present) → exactly three ch1 words released, one per edge.
- rst low during byte 1 of a 16-bit word → all outputs 0 next cycle; after release a new ch0 word transmits from byte 0; with RESULT_TX_HEADER_EN, header 0x82 precedes ch0's 2-byte word.
